usb_nrzi_rx_deser: RTL and testbench
====================================

USB_NRZI_RX_DESER -- requirements
Module: usb_nrzi_rx_deser

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of the assembled receive word (legal 2..32).
REQ-002 SHALL provide parameter STUFF_LEN, default 6, number of consecutive decoded ones after which one stuffed zero is expected (legal 2..15).
REQ-003 SHALL provide parameter IDLE_LEVEL, default 1, the d_plus line level (J) used as the NRZI reference whenever not receiving.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock for all state.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 d_plus  input  1  synchronised D+ line level.
REQ-007 shift_enable  input  1  one-cycle strobe marking the bit-centre sample of d_plus.
REQ-008 eop  input  1  end-of-packet detected on the line.
REQ-009 rcving  input  1  packet reception active; low aborts and idles the block.
REQ-010 d_orig  output  1  registered NRZI-decoded bit, stuffed bits included.
REQ-011 bit_valid  output  1  one-cycle pulse: a non-stuffed data bit was accepted.
REQ-012 rx_word  output  DATA_W  last completed word, LSB received first.
REQ-013 word_valid  output  1  one-cycle pulse: rx_word was just updated.
REQ-014 stuff_err  output  1  sticky bit-stuffing violation flag.

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, STUFF_CHK, ERROR; only ACTIVE, STUFF_CHK and ERROR are entered while rcving=1.
REQ-016 IDLE -> ACTIVE on rcving=1; any state -> IDLE on rcving=0, with priority over every other input.
REQ-017 On each shift_enable in ACTIVE or STUFF_CHK, the decoded bit SHALL be 1 if d_plus equals the stored previous level, else 0; the previous level then takes d_plus.
REQ-018 All outputs SHALL be registered, updating on the clock edge that samples shift_enable=1 (latency of one cycle from the strobe).
REQ-019 In ACTIVE, a decoded 1 SHALL increment a ones counter and a decoded 0 SHALL clear it; on reaching STUFF_LEN the FSM SHALL go to STUFF_CHK.
REQ-020 In STUFF_CHK, a decoded 0 SHALL be discarded (bit_valid stays 0), the ones counter SHALL clear and the FSM SHALL return to ACTIVE.
REQ-021 In STUFF_CHK, a decoded 1 SHALL set stuff_err and the FSM SHALL go to ERROR.
REQ-022 In ERROR, no bit_valid or word_valid SHALL be produced; d_orig continues to decode; exit only via rcving=0 or reset.
REQ-023 Each accepted bit SHALL shift into an internal DATA_W shift register at the MSB end (shift right) and increment a bit counter.
REQ-024 When the bit counter reaches DATA_W, rx_word SHALL load the full shift register, word_valid SHALL pulse, and the counter SHALL wrap to 0 in that same cycle.
REQ-025 rx_word SHALL hold its value until the next completed word or reset.
REQ-026 eop=1 together with shift_enable=1 SHALL: force d_orig=1, previous level=IDLE_LEVEL, clear ones and bit counters, discard the partial word, produce no bit_valid, and return the FSM to ACTIVE (from ERROR it stays ERROR); this has priority over stuff checking.
REQ-027 eop=1 without shift_enable SHALL have no effect.
REQ-028 rcving=0 SHALL set d_orig=1, previous level=IDLE_LEVEL, clear counters, shift register and stuff_err; rx_word is retained.

Reset
REQ-029 n_rst=0 SHALL asynchronously force: FSM IDLE, d_orig=1, previous level=IDLE_LEVEL, bit_valid=0, word_valid=0, rx_word=0, stuff_err=0, all counters and shift register 0.
REQ-030 Reset asserted mid-word SHALL discard all partial state; no word_valid SHALL follow reset release.

Verification (DATA_W=8, STUFF_LEN=6, IDLE_LEVEL=1)
REQ-031 Assert n_rst=0 mid-packet -> d_orig=1, rx_word=0x00, stuff_err=0, word_valid=0 immediately, without a clock edge.
REQ-032 rcving=1, d_plus samples 0,1,0,1,0,1,0,0 (SYNC) -> decoded 0,0,0,0,0,0,0,1; one word_valid with rx_word=0x80; eight bit_valid pulses.
REQ-033 After SYNC, d_plus 0,0,0,0,0,0 then 1 then 1,1 -> stuffed bit dropped (no bit_valid on 7th strobe); word_valid with rx_word=0xFF after 9 strobes; stuff_err=0.
REQ-034 After SYNC, d_plus held 0 for 7 strobes -> stuff_err=1 after the 7th; no further word_valid while rcving=1; rcving=0 clears stuff_err.
REQ-035 3 accepted bits then eop=1 with shift_enable -> no word_valid, d_orig=1; next 8 accepted bits form a fresh word with the correct value.
REQ-036 rcving dropped after 5 accepted bits, then restarted with a SYNC -> word_valid only for 0x80; rx_word held its prior value meanwhile.

Source files
------------

// File: rtl/usb_nrzi_rx_deser.sv
// USB receive front end: NRZI decode, bit-unstuffing and LSB-first word assembly.
// Sticky stuff_err flag; rcving=0 idles the block but keeps the last word.
module usb_nrzi_rx_deser #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STUFF_LEN  = 6,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_plus,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              rcving,
    output logic              d_orig,
    output logic              bit_valid,
    output logic [DATA_W-1:0] rx_word,
    output logic              word_valid,
    output logic              stuff_err
);

    localparam int unsigned ONES_W = 4;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACTIVE    = 2'd1,
        S_STUFF_CHK = 2'd2,
        S_ERROR     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prev,       w_prev_nxt;
    logic                r_d_orig,     w_d_orig_nxt;
    logic                r_bit_valid,  w_bit_valid_nxt;
    logic                r_word_valid, w_word_valid_nxt;
    logic                r_stuff_err,  w_stuff_err_nxt;
    logic [ONES_W-1:0]   r_ones,       w_ones_nxt;
    logic [CNT_W-1:0]    r_bit_cnt,    w_bit_cnt_nxt;
    logic [DATA_W-1:0]   r_shift,      w_shift_nxt;
    logic [DATA_W-1:0]   r_rx_word,    w_rx_word_nxt;

    logic                w_dec;
    logic                w_strobe;
    logic                w_word_done;
    logic                w_stuff_hit;
    logic [ONES_W-1:0]   w_ones_inc;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [DATA_W-1:0]   w_shift_in;

    assign w_dec       = (d_plus == r_prev);
    assign w_strobe    = rcving && shift_enable && (r_state != S_IDLE);
    assign w_ones_inc  = r_ones + ONES_W'(1);
    assign w_cnt_inc   = r_bit_cnt + CNT_W'(1);
    assign w_word_done = (w_cnt_inc == CNT_W'(DATA_W));
    assign w_shift_in  = {w_dec, r_shift[DATA_W-1:1]};
    // The ones run restarts at each word boundary, so a completing bit never arms the stuff check.
    assign w_stuff_hit = w_dec && (w_ones_inc == ONES_W'(STUFF_LEN)) && !w_word_done;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; rcving=0 overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!rcving) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_state_nxt = S_ACTIVE;
                S_ACTIVE: begin
                    if (shift_enable && !eop && w_stuff_hit) w_state_nxt = S_STUFF_CHK;
                end
                S_STUFF_CHK: begin
                    if (shift_enable) begin
                        if (eop)        w_state_nxt = S_ACTIVE;
                        else if (w_dec) w_state_nxt = S_ERROR;
                        else            w_state_nxt = S_ACTIVE;
                    end
                end
                S_ERROR:     w_state_nxt = S_ERROR;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        w_prev_nxt       = r_prev;
        w_d_orig_nxt     = r_d_orig;
        w_bit_valid_nxt  = 1'b0;
        w_word_valid_nxt = 1'b0;
        w_stuff_err_nxt  = r_stuff_err;
        w_ones_nxt       = r_ones;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rx_word_nxt    = r_rx_word;
        if (!rcving) begin
            w_prev_nxt      = IDLE_LEVEL;
            w_d_orig_nxt    = 1'b1;
            w_stuff_err_nxt = 1'b0;
            w_ones_nxt      = '0;
            w_bit_cnt_nxt   = '0;
            w_shift_nxt     = '0;
        end else if (w_strobe) begin
            w_prev_nxt   = d_plus;
            w_d_orig_nxt = w_dec;
            if (eop) begin
                w_prev_nxt    = IDLE_LEVEL;
                w_d_orig_nxt  = 1'b1;
                w_ones_nxt    = '0;
                w_bit_cnt_nxt = '0;
                w_shift_nxt   = '0;
            end else begin
                case (r_state)
                    S_ACTIVE: begin
                        w_bit_valid_nxt = 1'b1;
                        w_shift_nxt     = w_shift_in;
                        w_ones_nxt      = w_dec ? w_ones_inc : '0;
                        if (w_word_done) begin
                            w_rx_word_nxt    = w_shift_in;
                            w_word_valid_nxt = 1'b1;
                            w_bit_cnt_nxt    = '0;
                            w_ones_nxt       = '0;
                        end else begin
                            w_bit_cnt_nxt = w_cnt_inc;
                        end
                    end
                    S_STUFF_CHK: begin
                        w_ones_nxt = '0;
                        if (w_dec) w_stuff_err_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev       <= IDLE_LEVEL;
            r_d_orig     <= 1'b1;
            r_bit_valid  <= 1'b0;
            r_word_valid <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_ones       <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_word    <= '0;
        end else begin
            r_prev       <= w_prev_nxt;
            r_d_orig     <= w_d_orig_nxt;
            r_bit_valid  <= w_bit_valid_nxt;
            r_word_valid <= w_word_valid_nxt;
            r_stuff_err  <= w_stuff_err_nxt;
            r_ones       <= w_ones_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_word    <= w_rx_word_nxt;
        end
    end

    assign d_orig     = r_d_orig;
    assign bit_valid  = r_bit_valid;
    assign rx_word    = r_rx_word;
    assign word_valid = r_word_valid;
    assign stuff_err  = r_stuff_err;

endmodule

// File: tb/tb_usb_nrzi_rx_deser.sv
// Randomized bench for usb_nrzi_rx_deser against a queue-based receive model.
// Directed SYNC, stuffing, error, eop, abort and reset scenarios plus random packets.
module tb_usb_nrzi_rx_deser;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STUFF_LEN  = 6;
    localparam bit          IDLE_LEVEL = 1'b1;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              d_plus;
    logic              shift_enable;
    logic              eop;
    logic              rcving;
    logic              d_orig;
    logic              bit_valid;
    logic [DATA_W-1:0] rx_word;
    logic              word_valid;
    logic              stuff_err;

    usb_nrzi_rx_deser #(
        .DATA_W     (DATA_W),
        .STUFF_LEN  (STUFF_LEN),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .shift_enable (shift_enable),
        .eop          (eop),
        .rcving       (rcving),
        .d_orig       (d_orig),
        .bit_valid    (bit_valid),
        .rx_word      (rx_word),
        .word_valid   (word_valid),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int bv_count = 0;
    int wv_count = 0;

    // Receive model: line reference, run of ones in the current word, pending stuff bit, sticky error
    bit                m_prev;
    bit                m_d_orig;
    bit                m_bv;
    bit                m_wv;
    bit                m_err;
    bit                m_stuff_pend;
    int                m_ones;
    bit                m_bits[$];
    logic [DATA_W-1:0] m_word;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".d_orig"},     32'(d_orig),     32'(m_d_orig));
        chk({tag, ".bit_valid"},  32'(bit_valid),  32'(m_bv));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_wv));
        chk({tag, ".rx_word"},    32'(rx_word),    32'(m_word));
        chk({tag, ".stuff_err"},  32'(stuff_err),  32'(m_err));
    endtask

    task automatic model_idle();
        m_prev       = IDLE_LEVEL;
        m_d_orig     = 1'b1;
        m_bv         = 1'b0;
        m_wv         = 1'b0;
        m_err        = 1'b0;
        m_stuff_pend = 1'b0;
        m_ones       = 0;
        m_bits.delete();
    endtask

    // One bit-centre strobe, model update, check one cycle later, optional idle gap
    task automatic strobe(input bit d, input bit e, input string tag);
        bit dec;
        @(negedge clk);
        d_plus       = d;
        shift_enable = 1'b1;
        eop          = e;
        dec          = (d == m_prev);
        m_prev       = d;
        m_d_orig     = dec;
        m_bv         = 1'b0;
        m_wv         = 1'b0;
        if (e) begin
            m_d_orig     = 1'b1;
            m_prev       = IDLE_LEVEL;
            m_ones       = 0;
            m_stuff_pend = 1'b0;
            m_bits.delete();
        end else if (m_err) begin
            m_bv = 1'b0;
        end else if (m_stuff_pend) begin
            if (dec) m_err = 1'b1;
            m_stuff_pend = 1'b0;
            m_ones       = 0;
        end else begin
            m_bv = 1'b1;
            m_bits.push_back(dec);
            m_ones = dec ? m_ones + 1 : 0;
            if (m_bits.size() == DATA_W) begin
                m_word = '0;
                foreach (m_bits[i]) m_word[i] = m_bits[i];
                m_bits.delete();
                m_wv   = 1'b1;
                m_ones = 0;
            end else if (m_ones == STUFF_LEN) begin
                m_stuff_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        bv_count    += int'(bit_valid);
        wv_count    += int'(word_valid);
        shift_enable = 1'b0;
        eop          = 1'b0;
        m_bv         = 1'b0;
        m_wv         = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            check_outputs({tag, ".gap"});
        end
    endtask

    task automatic send_dec(input bit b, input string tag);
        strobe(b ? m_prev : ~m_prev, 1'b0, tag);
    endtask

    task automatic send_sync();
        bit pat[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        foreach (pat[i]) strobe(pat[i], 1'b0, "sync");
    endtask

    // Encode one word LSB first, inserting a stuffed zero after STUFF_LEN ones inside the word
    task automatic send_byte(input logic [DATA_W-1:0] v);
        int run = 0;
        for (int i = 0; i < DATA_W; i++) begin
            send_dec(v[i], "byte");
            run = v[i] ? run + 1 : 0;
            if (run == STUFF_LEN && i != DATA_W - 1) begin
                send_dec(1'b0, "stuff");
                run = 0;
            end
        end
    endtask

    task automatic start_rx();
        @(negedge clk);
        rcving = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop_rx(input string tag);
        @(negedge clk);
        rcving = 1'b0;
        model_idle();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        n_rst        = 1'b1;
        rcving       = 1'b0;
        d_plus       = IDLE_LEVEL;
        shift_enable = 1'b0;
        eop          = 1'b0;
        m_word       = '0;
        model_idle();
        #2 n_rst = 1'b0;
        #1 check_outputs("reset");
        #20;
        @(negedge clk) n_rst = 1'b1;

        // SYNC decodes to 0x80
        start_rx();
        bv_count = 0;
        wv_count = 0;
        send_sync();
        chk("sync_bv_cnt", 32'(bv_count), 32'd8);
        chk("sync_wv_cnt", 32'(wv_count), 32'd1);
        chk("sync_word",   32'(rx_word),  32'h80);

        // Six ones, stuffed zero dropped, two more ones -> 0xFF
        bv_count = 0;
        wv_count = 0;
        repeat (6) strobe(1'b0, 1'b0, "run");
        strobe(1'b1, 1'b0, "stuffbit");
        chk("stuff_dropped", 32'(bit_valid), 32'd0);
        strobe(1'b1, 1'b0, "run");
        strobe(1'b1, 1'b0, "run");
        chk("ff_word",   32'(rx_word),   32'hFF);
        chk("ff_bv_cnt", 32'(bv_count),  32'd8);
        chk("ff_wv_cnt", 32'(wv_count),  32'd1);
        chk("ff_no_err", 32'(stuff_err), 32'd0);
        stop_rx("stop1");

        // Seven ones in a row -> sticky stuff error
        start_rx();
        send_sync();
        wv_count = 0;
        repeat (7) strobe(1'b0, 1'b0, "viol");
        chk("stuff_err_set", 32'(stuff_err), 32'd1);
        repeat (12) strobe(1'($urandom_range(0, 1)), 1'b0, "in_err");
        chk("err_no_wv", 32'(wv_count), 32'd0);
        stop_rx("stop_err");
        chk("stuff_err_clr", 32'(stuff_err), 32'd0);

        // eop discards a partial word; next word assembles cleanly
        start_rx();
        send_sync();
        wv_count = 0;
        repeat (3) send_dec(1'($urandom_range(0, 1)), "part");
        strobe(IDLE_LEVEL, 1'b1, "eop");
        chk("eop_d_orig", 32'(d_orig),   32'd1);
        chk("eop_no_wv",  32'(wv_count), 32'd0);
        v = DATA_W'($urandom);
        send_byte(v);
        chk("eop_fresh_word", 32'(rx_word),  32'(v));
        chk("eop_fresh_wv",   32'(wv_count), 32'd1);

        // Abort after 5 bits, restart with SYNC
        wv_count = 0;
        repeat (5) send_dec(1'($urandom_range(0, 1)), "abort");
        stop_rx("abort_stop");
        chk("abort_hold", 32'(rx_word), 32'(v));
        start_rx();
        send_sync();
        chk("restart_wv_cnt", 32'(wv_count), 32'd1);
        chk("restart_word",   32'(rx_word),  32'h80);

        // Random byte stream
        repeat (20) begin
            v = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) v = '1;
            send_byte(v);
            chk("rand_byte", 32'(rx_word), 32'(v));
        end
        stop_rx("stop_bytes");

        // Random line activity biased toward long runs, with occasional eop
        repeat (8) begin
            start_rx();
            send_sync();
            repeat ($urandom_range(10, 60)) begin
                if ($urandom_range(0, 19) == 0)
                    strobe(IDLE_LEVEL, 1'b1, "rnd_eop");
                else
                    strobe(($urandom_range(0, 2) == 0) ? ~m_prev : m_prev, 1'b0, "rnd");
            end
            stop_rx("rnd_stop");
        end

        // Asynchronous reset mid-word
        start_rx();
        send_sync();
        repeat (3) send_dec(1'($urandom_range(0, 1)), "pre_rst");
        @(negedge clk);
        #2;
        n_rst  = 1'b0;
        rcving = 1'b0;
        m_word = '0;
        model_idle();
        #1 check_outputs("async_reset");
        @(negedge clk) n_rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1 chk("post_reset_wv", 32'(word_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
